// File: rtl/rijndael_keyexpand.sv
`default_nettype none
// ============================================================================
// Module   : rijndael_keyexpand (plus leaf rijndael_sbox)
// Purpose  : Iterative Rijndael key-schedule engine. Accepts an NK-word cipher
//            key and streams the NR+1 round keys (NB words each) in round
//            order over a valid/ready handshake. One schedule word is
//            produced per cycle; SubWord uses four rijndael_sbox instances.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            key_i             - cipher key, byte k at [8k+7:8k]
//            key_valid_i/key_ready_o - key handshake (ready only when idle)
//            rk_o              - round key, word j at [32j+31:32j]
//            rk_idx_o          - round index of rk_o (0..NR)
//            rk_last_o         - marks the round key with index NR
//            rk_valid_o/rk_ready_i - round-key handshake
//            busy_o            - key accepted, last round key not yet taken
//            abort_i           - only when RIJNDAEL_KEYEXPAND_ABORT_EN is
//                                defined; behaves exactly like rst
// Options  : `define RIJNDAEL_KEYEXPAND_ABORT_EN adds the abort_i port.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// rijndael_sbox : combinational forward S-box lookup.
// ----------------------------------------------------------------------------
module rijndael_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry x lives at bits [8*(255-x)+7 : 8*(255-x)], i.e. row 0 is the MSBs.
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // 8*(255-x) == {~x, 3'b000}
  assign out_o = C_SBOX[{~in_i, 3'b000} +: 8];

endmodule

// ----------------------------------------------------------------------------
// rijndael_keyexpand : key-schedule engine.
// ----------------------------------------------------------------------------
module rijndael_keyexpand #(
  parameter int NB = 4,
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef RIJNDAEL_KEYEXPAND_ABORT_EN
  input  logic              abort_i,
`endif
  input  logic [32*NK-1:0]  key_i,
  input  logic              key_valid_i,
  output logic              key_ready_o,
  output logic [32*NB-1:0]  rk_o,
  output logic [3:0]        rk_idx_o,
  output logic              rk_last_o,
  output logic              rk_valid_o,
  input  logic              rk_ready_i,
  output logic              busy_o
);

  localparam int NR         = ((NB > NK) ? NB : NK) + 6;
  localparam int TOTALWORDS = NB * (NR + 1);

  localparam logic [6:0] C_LAST_WORD = 7'(TOTALWORDS - 1);
  localparam logic [6:0] C_NK_WORDS  = 7'(NK);
  localparam logic [2:0] C_NK_LAST   = 3'(NK - 1);
  localparam logic [3:0] C_NB_LAST   = 4'(NB - 1);
  localparam logic [3:0] C_NB_FULL   = 4'(NB);
  localparam logic [3:0] C_NR        = 4'(NR);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         state_q,    state_d;
  // Sliding window of the last NK schedule words; [0] = w[i-NK], [NK-1] = w[i-1]
  logic [31:0]        win_q [NK];
  logic [31:0]        win_d [NK];
  logic [6:0]         wcnt_q,     wcnt_d;     // word counter i
  logic [2:0]         kmod_q,     kmod_d;     // i mod NK, tracked incrementally
  logic [7:0]         rcon_q,     rcon_d;
  logic [31:0]        acc_q [NB];
  logic [31:0]        acc_d [NB];
  logic [3:0]         acc_cnt_q,  acc_cnt_d;  // words held in the accumulator
  logic [3:0]         round_q,    round_d;    // index of the next round key to issue
  logic [32*NB-1:0]   rk_q,       rk_d;
  logic [3:0]         rk_idx_q,   rk_idx_d;
  logic               rk_valid_q, rk_valid_d;
  logic               rk_last_q,  rk_last_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic               clr;
  logic [31:0]        prev_word;
  logic [31:0]        sub_in;
  logic [31:0]        sub_out;
  logic [31:0]        t_word;
  logic [31:0]        new_word;
  logic               out_free;
  logic               acc_full;
  logic               gen;
  logic [31:0]        acc_ins [NB];

`ifdef RIJNDAEL_KEYEXPAND_ABORT_EN
  assign clr = rst | abort_i;
`else
  assign clr = rst;
`endif

  assign prev_word = win_q[NK-1];

  // RotWord moves byte 1 into byte 0; with byte 0 in the low bits that is a
  // rotate right by 8.
  assign sub_in = (kmod_q == 3'd0) ? {prev_word[7:0], prev_word[31:8]} : prev_word;

  generate
    for (genvar b = 0; b < 4; b++) begin : g_sbox
      rijndael_sbox u_sbox (
        .in_i  (sub_in[8*b +: 8]),
        .out_o (sub_out[8*b +: 8])
      );
    end
  endgenerate

  always_comb begin
    t_word = prev_word;
    if (kmod_q == 3'd0) begin
      t_word = sub_out ^ {24'h0, rcon_q};
    end else if ((NK > 6) && (kmod_q == 3'd4)) begin
      t_word = sub_out;
    end
  end

  // For i < NK the window is simply rotated, so its head is key word i and
  // after NK steps the window again holds w[0..NK-1] in order.
  assign new_word = (wcnt_q < C_NK_WORDS) ? win_q[0] : (win_q[0] ^ t_word);

  assign out_free = !rk_valid_q || rk_ready_i;
  assign acc_full = (acc_cnt_q == C_NB_FULL);
  // The only stall: a complete round key is waiting behind an unaccepted one.
  assign gen      = (state_q == ST_GEN) && !(acc_full && !out_free);

  // Accumulator contents with this cycle's word written into its slot.
  always_comb begin
    for (int j = 0; j < NB; j++) begin
      acc_ins[j] = acc_q[j];
      if (acc_cnt_q == 4'(j)) begin
        acc_ins[j] = new_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    wcnt_d     = wcnt_q;
    kmod_d     = kmod_q;
    rcon_d     = rcon_q;
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    round_d    = round_q;
    rk_d       = rk_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = rk_valid_q;
    rk_last_d  = rk_last_q;

    // Consumer takes the current round key.
    if (rk_valid_q && rk_ready_i) begin
      rk_valid_d = 1'b0;
      rk_last_d  = 1'b0;
    end

    // Accumulator / output register transfer.
    if (acc_full) begin
      if (out_free) begin
        for (int j = 0; j < NB; j++) begin
          rk_d[32*j +: 32] = acc_q[j];
        end
        rk_idx_d   = round_q;
        rk_last_d  = (round_q == C_NR);
        rk_valid_d = 1'b1;
        round_d    = round_q + 4'd1;
        acc_cnt_d  = 4'd0;
        // The freed accumulator immediately receives this cycle's word.
        if (gen) begin
          acc_d[0]  = new_word;
          acc_cnt_d = 4'd1;
        end
      end
    end else if (gen) begin
      acc_d = acc_ins;
      if ((acc_cnt_q == C_NB_LAST) && out_free) begin
        // Completing word bypasses the accumulator straight into rk_o.
        for (int j = 0; j < NB; j++) begin
          rk_d[32*j +: 32] = acc_ins[j];
        end
        rk_idx_d   = round_q;
        rk_last_d  = (round_q == C_NR);
        rk_valid_d = 1'b1;
        round_d    = round_q + 4'd1;
        acc_cnt_d  = 4'd0;
      end else begin
        acc_cnt_d = acc_cnt_q + 4'd1;
      end
    end

    // Schedule word generation.
    if (gen) begin
      for (int k = 0; k < NK - 1; k++) begin
        win_d[k] = win_q[k+1];
      end
      win_d[NK-1] = new_word;
      wcnt_d      = wcnt_q + 7'd1;
      kmod_d      = (kmod_q == C_NK_LAST) ? 3'd0 : (kmod_q + 3'd1);
      if ((wcnt_q >= C_NK_WORDS) && (kmod_q == 3'd0)) begin
        // xtime modulo x^8+x^4+x^3+x+1; keeps going past 0x36 when needed.
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
    end

    // Control FSM.
    case (state_q)
      ST_IDLE: begin
        if (key_valid_i) begin
          for (int k = 0; k < NK; k++) begin
            win_d[k] = key_i[32*k +: 32];
          end
          wcnt_d    = 7'd0;
          kmod_d    = 3'd0;
          rcon_d    = 8'h01;
          acc_cnt_d = 4'd0;
          round_d   = 4'd0;
          state_d   = ST_GEN;
        end
      end
      ST_GEN: begin
        if (gen && (wcnt_q == C_LAST_WORD)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rk_valid_q && rk_ready_i && rk_last_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 7'd0;
      kmod_q     <= 3'd0;
      rcon_q     <= 8'h01;
      acc_cnt_q  <= 4'd0;
      round_q    <= 4'd0;
      rk_q       <= '0;
      rk_idx_q   <= 4'd0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      for (int k = 0; k < NK; k++) begin
        win_q[k] <= 32'h0;
      end
      for (int j = 0; j < NB; j++) begin
        acc_q[j] <= 32'h0;
      end
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      kmod_q     <= kmod_d;
      rcon_q     <= rcon_d;
      acc_cnt_q  <= acc_cnt_d;
      round_q    <= round_d;
      rk_q       <= rk_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign key_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rk_o        = rk_q;
  assign rk_idx_o    = rk_idx_q;
  assign rk_valid_o  = rk_valid_q;
  assign rk_last_o   = rk_last_q;

endmodule

`default_nettype wire
